// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with hold, bubble insertion and optional perf counters (ID_EX_PERF_CNT_EN)
module id_ex_register #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [7:0]        id_instr,
  input  logic [1:0]        id_ra,
  input  logic [1:0]        id_rb,
  input  logic [1:0]        id_reg_dest,
  input  logic [DATA_W-1:0] id_ra_data,
  input  logic [DATA_W-1:0] id_rb_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_ex_flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [7:0]        ex_instr,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_ra,
  output logic [1:0]        ex_rb,
  output logic [DATA_W-1:0] ex_ra_data,
  output logic [DATA_W-1:0] ex_rb_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              id_ex_mem_read,
  output logic              id_ex_is_load,
  output logic [1:0]        id_ex_reg_dest,
  output logic [1:0]        ex_state,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  hold_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Edge classification; hold beats flush beats an empty decode slot.
  logic do_hold;
  logic do_flush;
  logic do_bubble;
  logic do_load;

  assign do_hold   = ex_hold;
  assign do_flush  = !ex_hold && id_ex_flush;
  assign do_bubble = !ex_hold && (id_ex_flush || !id_valid);
  assign do_load   = !ex_hold && !id_ex_flush && id_valid;

  logic [1:0] state_next;

  // Next FSM state: an empty decode slot without a flush still counts as RUN.
  always_comb begin
    state_next = ST_RUN;
    if (do_hold) begin
      state_next = ST_HOLD;
    end else if (do_flush) begin
      state_next = ST_BUBBLE;
    end
  end

  // Pipeline payload: freeze on hold, zero on bubble, capture on normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_instr       <= 8'h00;
      ex_alu_op      <= 4'h0;
      ex_ra          <= 2'd0;
      ex_rb          <= 2'd0;
      ex_ra_data     <= '0;
      ex_rb_data     <= '0;
      ex_imm         <= '0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      id_ex_mem_read <= 1'b0;
      id_ex_is_load  <= 1'b0;
      id_ex_reg_dest <= 2'd0;
    end else if (do_bubble) begin
      ex_valid       <= 1'b0;
      ex_instr       <= 8'h00;
      ex_alu_op      <= 4'h0;
      ex_ra          <= 2'd0;
      ex_rb          <= 2'd0;
      ex_ra_data     <= '0;
      ex_rb_data     <= '0;
      ex_imm         <= '0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      id_ex_mem_read <= 1'b0;
      id_ex_is_load  <= 1'b0;
      id_ex_reg_dest <= 2'd0;
    end else if (do_load) begin
      ex_valid       <= 1'b1;
      ex_instr       <= id_instr;
      ex_alu_op      <= id_alu_op;
      ex_ra          <= id_ra;
      ex_rb          <= id_rb;
      ex_ra_data     <= id_ra_data;
      ex_rb_data     <= id_rb_data;
      ex_imm         <= id_imm;
      ex_mem_write   <= id_mem_write;
      ex_reg_write   <= id_reg_write;
      id_ex_mem_read <= id_mem_read;
      id_ex_is_load  <= id_is_load;
      id_ex_reg_dest <= id_reg_dest;
    end
  end

  // FSM register; reflects the kind of update applied on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_state <= ST_RUN;
    end else begin
      ex_state <= state_next;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;

  // Flush-induced bubbles only; empty decode slots are not stalls worth counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (do_flush && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // Every held edge counts, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (do_hold && (hold_cnt_q != CNT_MAX)) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end

  assign bubble_count = bubble_cnt_q;
  assign hold_count   = hold_cnt_q;
`else
  assign bubble_count = '0;
  assign hold_count   = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed self-checking bench for id_ex_register
module tb_id_ex_register;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [7:0]        id_instr;
  logic [1:0]        id_ra, id_rb, id_reg_dest;
  logic [DATA_W-1:0] id_ra_data, id_rb_data, id_imm;
  logic [3:0]        id_alu_op;
  logic              id_mem_read, id_mem_write, id_reg_write, id_is_load;
  logic              id_ex_flush, ex_hold;
  logic              ex_valid;
  logic [7:0]        ex_instr;
  logic [3:0]        ex_alu_op;
  logic [1:0]        ex_ra, ex_rb;
  logic [DATA_W-1:0] ex_ra_data, ex_rb_data, ex_imm;
  logic              ex_mem_write, ex_reg_write;
  logic              id_ex_mem_read, id_ex_is_load;
  logic [1:0]        id_ex_reg_dest;
  logic [1:0]        ex_state;
  logic [CNT_W-1:0]  bubble_count, hold_count;

  int passed = 0;
  int total  = 0;

  id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_ra(id_ra), .id_rb(id_rb), .id_reg_dest(id_reg_dest),
    .id_ra_data(id_ra_data), .id_rb_data(id_rb_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_ex_flush(id_ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_alu_op(ex_alu_op),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_ra_data(ex_ra_data), .ex_rb_data(ex_rb_data),
    .ex_imm(ex_imm), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_is_load(id_ex_is_load),
    .id_ex_reg_dest(id_ex_reg_dest), .ex_state(ex_state),
    .bubble_count(bubble_count), .hold_count(hold_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ins, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                       input logic [3:0] op, input logic mr, input logic mw, input logic rw, input logic ld);
    id_valid = v; id_instr = ins; id_ra = ra; id_rb = rb; id_reg_dest = rd;
    id_ra_data = a; id_rb_data = b; id_imm = imm; id_alu_op = op;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw; id_is_load = ld;
  endtask

  // All-zero payload checks shared by reset and bubble points.
  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(ex_valid), 32'h0);
    check({tag, "_instr"}, 32'(ex_instr), 32'h0);
    check({tag, "_ctrl"}, 32'({ex_alu_op, ex_mem_write, ex_reg_write, id_ex_mem_read, id_ex_is_load}), 32'h0);
    check({tag, "_idx"}, 32'({ex_ra, ex_rb, id_ex_reg_dest}), 32'h0);
    check({tag, "_data"}, 32'({ex_ra_data, ex_rb_data, ex_imm}), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; id_ex_flush = 1'b0; ex_hold = 1'b0;
    drive(1'b1, 8'hA5, 2'd1, 2'd2, 2'd3, 8'h11, 8'h22, 8'h33, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    check_zero("reset");
    check("reset_state", 32'(ex_state), 32'd0);
    check("reset_cnt", 32'({bubble_count, hold_count}), 32'h0);
    #5;
    check("reset_over_edge_valid", 32'(ex_valid), 32'h0);
    rst_n = 1'b1;

    // Plain instruction, one-cycle latency.
    drive(1'b1, 8'h2B, 2'd1, 2'd3, 2'd2, 8'h5A, 8'hC3, 8'h7E, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("run_instr", 32'(ex_instr), 32'h2B);
    check("run_valid", 32'(ex_valid), 32'h1);
    check("run_state", 32'(ex_state), 32'd0);
    check("run_idx", 32'({ex_ra, ex_rb, id_ex_reg_dest}), 32'({2'd1, 2'd3, 2'd2}));
    check("run_data", 32'({ex_ra_data, ex_rb_data, ex_imm}), 32'h5AC37E);
    check("run_ctrl", 32'({ex_alu_op, ex_mem_write, ex_reg_write, id_ex_mem_read, id_ex_is_load}), 32'h9C);

    // Load followed by a flush.
    drive(1'b1, 8'h61, 2'd0, 2'd1, 2'd2, 8'h10, 8'h20, 8'h04, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("ldd_is_load", 32'(id_ex_is_load), 32'h1);
    check("ldd_reg_dest", 32'(id_ex_reg_dest), 32'd2);
    check("ldd_mem_read", 32'(id_ex_mem_read), 32'h1);
    id_ex_flush = 1'b1;
    tick();
    check_zero("flush");
    check("flush_state", 32'(ex_state), 32'd1);
    check("flush_bubble_cnt", 32'(bubble_count), PERF ? 32'd1 : 32'd0);
    check("flush_hold_cnt", 32'(hold_count), 32'd0);

    // Empty decode slot: bubble, RUN state, not counted.
    id_ex_flush = 1'b0;
    id_valid = 1'b0;
    tick();
    check("idle_valid", 32'(ex_valid), 32'h0);
    check("idle_instr", 32'(ex_instr), 32'h0);
    check("idle_state", 32'(ex_state), 32'd0);
    check("idle_bubble_cnt", 32'(bubble_count), PERF ? 32'd1 : 32'd0);

    // Hold with a simultaneous flush for three edges.
    drive(1'b1, 8'h3C, 2'd3, 2'd0, 2'd1, 8'hAA, 8'h55, 8'h0F, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("pre_hold_instr", 32'(ex_instr), 32'h3C);
    ex_hold = 1'b1; id_ex_flush = 1'b1;
    drive(1'b1, 8'hEE, 2'd1, 2'd1, 2'd0, 8'h01, 8'h02, 8'h03, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_instr", 32'(ex_instr), 32'h3C);
      check("hold_state", 32'(ex_state), 32'd2);
      check("hold_valid", 32'(ex_valid), 32'h1);
    end
    check("hold_load_fields", 32'({id_ex_is_load, id_ex_reg_dest, id_ex_mem_read}), 32'b1011);
    check("hold_data", 32'({ex_ra_data, ex_rb_data, ex_imm}), 32'hAA550F);
    check("hold_cnt", 32'(hold_count), PERF ? 32'd3 : 32'd0);
    check("hold_bubble_cnt", 32'(bubble_count), PERF ? 32'd1 : 32'd0);

    // Leave hold: the waiting decode instruction is captured once.
    ex_hold = 1'b0; id_ex_flush = 1'b0;
    drive(1'b1, 8'h44, 2'd2, 2'd1, 2'd3, 8'h12, 8'h34, 8'h56, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("resume_instr", 32'(ex_instr), 32'h44);
    check("resume_state", 32'(ex_state), 32'd0);
    check("resume_hold_cnt", 32'(hold_count), PERF ? 32'd3 : 32'd0);

    // Reset pulsed mid-hold, away from the clock edge.
    drive(1'b1, 8'h55, 2'd1, 2'd1, 2'd1, 8'h99, 8'h88, 8'h77, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    ex_hold = 1'b1;
    tick();
    check("midhold_state", 32'(ex_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    check("async_rst_state", 32'(ex_state), 32'd0);
    check("async_rst_cnt", 32'({bubble_count, hold_count}), 32'h0);
    #1 rst_n = 1'b1;
    ex_hold = 1'b0;
    drive(1'b1, 8'h66, 2'd2, 2'd2, 2'd1, 8'h01, 8'h80, 8'hFF, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_instr", 32'(ex_instr), 32'h66);
    check("post_rst_valid", 32'(ex_valid), 32'h1);
    check("post_rst_data", 32'({ex_ra_data, ex_rb_data, ex_imm}), 32'h0180FF);

    // Bubble counter saturation.
    id_ex_flush = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("bubble_cnt_254", 32'(bubble_count), PERF ? 32'd254 : 32'd0);
    for (int i = 0; i < 46; i++) tick();
    check("bubble_cnt_sat", 32'(bubble_count), PERF ? 32'd255 : 32'd0);
    check("sat_state", 32'(ex_state), 32'd1);
    check("sat_valid", 32'(ex_valid), 32'h0);
    id_ex_flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, width of operand and immediate fields.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_instr  input  8  instruction byte in decode.
REQ-007 id_ra, id_rb, id_reg_dest  input  2 each  source A, source B and destination register indices.
REQ-008 id_ra_data, id_rb_data, id_imm  input  DATA_W each  operand values and immediate.
REQ-009 id_alu_op  input  4  ALU operation select.
REQ-010 id_mem_read, id_mem_write, id_reg_write, id_is_load  input  1 each  decoded control bits.
REQ-011 id_ex_flush  input  1  bubble-insert request from hazard detection.
REQ-012 ex_hold  input  1  downstream multi-cycle stall; freeze EX contents.
REQ-013 ex_valid  output  1  EX holds a real instruction.
REQ-014 ex_instr, ex_alu_op, ex_ra, ex_rb, ex_ra_data, ex_rb_data, ex_imm, ex_mem_write, ex_reg_write  output  registered copies of the matching id_* inputs.
REQ-015 id_ex_mem_read, id_ex_is_load, id_ex_reg_dest  output  1/1/2  registered EX-stage fields, fed back to hazard detection.
REQ-016 ex_state  output  2  RUN=0, BUBBLE=1, HOLD=2.
REQ-017 bubble_count, hold_count  output  CNT_W each  performance counters.

Function
REQ-018 Latency SHALL be exactly one clock from the id_* inputs to the ex_* outputs.
REQ-019 Per-edge priority SHALL be ex_hold > id_ex_flush > (id_valid==0) > normal load.
REQ-020 With ex_hold=1, every ex_* and id_ex_* output SHALL retain its value, and id_ex_flush SHALL be ignored that cycle.
REQ-021 A bubble, from id_ex_flush=1 or id_valid=0, SHALL load ex_valid=0, ex_instr=8'h00, every control bit 0, and every register index and data field 0.
REQ-022 A normal load SHALL set ex_valid=1 and capture every id_* field unchanged.
REQ-023 FSM: the next state SHALL be HOLD if ex_hold, else BUBBLE if id_ex_flush, else RUN.
REQ-024 ex_state SHALL show the state entered on the current edge, consistent with the EX contents.
REQ-025 While holding, id_ex_is_load and id_ex_reg_dest SHALL stay stable, so a load-use stall persists across the hold.
REQ-026 Leaving HOLD SHALL resume per REQ-019 on the first edge with ex_hold=0, with no lost or duplicated instruction.
REQ-027 bubble_count SHALL increment by 1 on each edge that inserts a bubble due to id_ex_flush, saturating at 2^CNT_W-1.
REQ-028 hold_count SHALL increment by 1 on each edge with ex_hold=1, saturating at 2^CNT_W-1.
REQ-029 Bubbles caused only by id_valid=0 SHALL NOT be counted.

Reset
REQ-030 While rst_n=0, all outputs SHALL go immediately to 0 without waiting for clk: ex_valid=0, ex_instr=8'h00, control bits 0, ex_state=RUN, both counters 0.
REQ-031 Reset asserted mid-hold or mid-bubble SHALL discard that operation.
REQ-032 The first edge after rst_n deassertion SHALL follow REQ-019.

Configuration
REQ-033 Macro ID_EX_PERF_CNT_EN: when defined, bubble_count and hold_count SHALL behave per REQ-027 to REQ-029.
REQ-034 When ID_EX_PERF_CNT_EN is undefined, the counter registers SHALL be absent, both outputs SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Scenario: id_instr=8'h2B, id_valid=1, no flush or hold -> next edge ex_instr=8'h2B, ex_valid=1, ex_state=RUN.
REQ-036 Scenario: LDD with id_is_load=1, id_reg_dest=2 loaded, then id_ex_flush=1 for one cycle -> id_ex_is_load=1 and id_ex_reg_dest=2 after edge 1; ex_valid=0, ex_instr=8'h00, ex_state=BUBBLE after edge 2; bubble_count=1.
REQ-037 Scenario: ex_hold=1 and id_ex_flush=1 together for 3 cycles -> EX contents unchanged, ex_state=HOLD, hold_count=3, bubble_count unchanged.
REQ-038 Scenario: 300 consecutive flushes with CNT_W=8 -> bubble_count saturates at 255.
REQ-039 Scenario: rst_n pulsed low mid-hold, away from any clk edge -> all outputs 0 and ex_state=RUN immediately; the next valid instruction is captured normally.
REQ-040 Scenario: build without ID_EX_PERF_CNT_EN and rerun REQ-036 -> bubble_count=0 and all other outputs identical.
